// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// instruction classes, opcode values and ALU operation classes.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_I     = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BEQ   = 3'd4
  } iclass_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

endpackage

// File: rtl/multicycle_control_opcode_decoder.sv
// Maps a 7-bit major opcode onto an instruction class plus a legal flag.
module opcode_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = CLS_R;
    legal  = 1'b1;
    case (opcode)
      OP_R:     iclass = CLS_R;
      OP_I:     iclass = CLS_I;
      OP_LOAD:  iclass = CLS_LOAD;
      OP_STORE: iclass = CLS_STORE;
      OP_BEQ:   iclass = CLS_BEQ;
      default:  legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing,
// registered instruction class, illegal-opcode trap and retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [31:0] INSTRET_INIT = '0
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic        retire,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  state_t      state_reg, state_next;
  iclass_t     class_reg;
  iclass_t     dec_class;
  logic        dec_legal;
  logic [31:0] instret_reg;

  logic       imem_req_c, ir_write_c, pc_write_c, pc_src_c, alu_src_c;
  logic [1:0] alu_op_c;
  logic       dmem_req_c, dmem_we_c, mem_to_reg_c, reg_write_c, illegal_c, retire_c;

  opcode_decoder u_decoder (
    .opcode (opcode),
    .iclass (dec_class),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      class_reg   <= CLS_R;
      instret_reg <= INSTRET_INIT;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE)
        class_reg <= dec_class;
      if (retire_c)
        instret_reg <= instret_reg + 32'd1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    imem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = ALUOP_ADD;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    retire_c     = 1'b0;
    case (state_reg)
      FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = dec_legal ? EXECUTE : TRAP;
      EXECUTE: begin
        // Driven from the class captured in DECODE; the IR may already be changing.
        case (class_reg)
          CLS_R: begin
            alu_op_c   = ALUOP_RFUNCT;
            state_next = WRITEBACK;
          end
          CLS_I: begin
            alu_src_c  = 1'b1;
            alu_op_c   = ALUOP_IFUNCT;
            state_next = WRITEBACK;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_c  = 1'b1;
            state_next = MEMORY;
          end
          CLS_BEQ: begin
            alu_op_c   = ALUOP_SUB;
            pc_write_c = zero;
            pc_src_c   = 1'b1;
            retire_c   = 1'b1;
            state_next = FETCH;
          end
          default: state_next = TRAP;
        endcase
      end
      MEMORY: begin
        alu_src_c  = 1'b1;
        dmem_req_c = 1'b1;
        dmem_we_c  = (class_reg == CLS_STORE);
        if (dmem_ready) begin
          if (class_reg == CLS_STORE) begin
            retire_c   = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (class_reg == CLS_LOAD);
        alu_src_c    = (class_reg != CLS_R);
        alu_op_c     = (class_reg == CLS_R) ? ALUOP_RFUNCT :
                       (class_reg == CLS_I) ? ALUOP_IFUNCT : ALUOP_ADD;
        retire_c     = 1'b1;
        state_next   = FETCH;
      end
      TRAP:    illegal_c  = 1'b1;
      default: state_next = FETCH;
    endcase
  end

  // Reset forces every output low combinationally, even before the first edge.
  assign imem_req   = imem_req_c   & ~reset;
  assign ir_write   = ir_write_c   & ~reset;
  assign pc_write   = pc_write_c   & ~reset;
  assign pc_src     = pc_src_c     & ~reset;
  assign alu_src    = alu_src_c    & ~reset;
  assign alu_op     = reset ? 2'b00 : alu_op_c;
  assign dmem_req   = dmem_req_c   & ~reset;
  assign dmem_we    = dmem_we_c    & ~reset;
  assign mem_to_reg = mem_to_reg_c & ~reset;
  assign reg_write  = reg_write_c  & ~reset;
  assign illegal    = illegal_c    & ~reset;
  assign retire     = retire_c     & ~reset;
  assign instret    = reset ? 32'd0 : instret_reg;
  assign state      = reset ? 3'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// instructions with random wait states, checked against a latency/count model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, ir_write, pc_write, pc_src, alu_src;
  logic [1:0]  alu_op;
  logic        dmem_req, dmem_we, mem_to_reg, reg_write, illegal, retire;
  logic [31:0] instret;
  logic [2:0]  state;

  logic        w_imem_req, w_ir_write, w_pc_write, w_pc_src, w_alu_src;
  logic [1:0]  w_alu_op;
  logic        w_dmem_req, w_dmem_we, w_mem_to_reg, w_reg_write, w_illegal, w_retire;
  logic [31:0] w_instret;
  logic [2:0]  w_state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret;
  logic [31:0] w_exp_instret;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src(alu_src), .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .retire(retire), .instret(instret), .state(state)
  );

  // Second instance whose counter resets just below the wrap point.
  multicycle_control #(.INSTRET_INIT(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(w_imem_req), .ir_write(w_ir_write), .pc_write(w_pc_write), .pc_src(w_pc_src),
    .alu_src(w_alu_src), .alu_op(w_alu_op), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
    .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write), .illegal(w_illegal),
    .retire(w_retire), .instret(w_instret), .state(w_state)
  );

  function automatic logic [12:0] ctrl_vec();
    return {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
            dmem_req, dmem_we, mem_to_reg, reg_write, illegal, retire};
  endfunction

  // Reference model: zero-wait latency per class, plus one cycle per wait state.
  function automatic int base_latency(input logic [6:0] op);
    if (op == OP_BEQ)  return 3;
    if (op == OP_LOAD) return 5;
    return 4;
  endfunction

  function automatic bit is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic bit writes_reg(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD);
  endfunction

  // One instruction: k fetch wait cycles, m memory wait cycles.
  task automatic run_instr(input logic [6:0] op, input logic z, input int k, input int m);
    int cyc, imem_cnt, dmem_cnt, we_cnt, rw_cnt, m2r_cnt, pcw_cnt, br_cnt, lat;
    int exp_lat, exp_dmem;
    bit done;
    imem_cnt = 0; dmem_cnt = 0; we_cnt = 0; rw_cnt = 0; m2r_cnt = 0;
    pcw_cnt = 0; br_cnt = 0; lat = 0; done = 0;
    for (cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      opcode     = (cyc <= k + 1) ? op : 7'($urandom);
      zero       = z;
      imem_ready = (cyc >= k);
      dmem_ready = (dmem_cnt >= m);
      #1;
      if (cyc == 0) begin
        checks++;
        if (instret !== exp_instret) begin
          errors++;
          $display("FAIL instret_count op=%b: got %h expected %h", op, instret, exp_instret);
        end
      end
      checks++;
      if ((pc_write && reg_write) || (imem_req && dmem_req) || illegal) begin
        errors++;
        $display("FAIL exclusivity op=%b cyc=%0d: pcw=%b rw=%b ireq=%b dreq=%b ill=%b expected no overlap",
                 op, cyc, pc_write, reg_write, imem_req, dmem_req, illegal);
      end
      if (imem_req) imem_cnt++;
      if (dmem_req) dmem_cnt++;
      if (dmem_req && dmem_we) we_cnt++;
      if (reg_write) rw_cnt++;
      if (reg_write && mem_to_reg) m2r_cnt++;
      if (pc_write) pcw_cnt++;
      if (pc_write && pc_src) br_cnt++;
      if (retire) begin
        lat  = cyc + 1;
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL retire_timeout op=%b: no retire within 80 cycles, expected one", op);
      return;
    end
    exp_lat  = base_latency(op) + k + (is_mem(op) ? m : 0);
    exp_dmem = is_mem(op) ? m + 1 : 0;
    checks += 7;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL latency op=%b k=%0d m=%0d: got %0d expected %0d", op, k, m, lat, exp_lat);
    end
    if (imem_cnt !== k + 1) begin
      errors++; $display("FAIL imem_req_cycles op=%b: got %0d expected %0d", op, imem_cnt, k + 1);
    end
    if (dmem_cnt !== exp_dmem) begin
      errors++; $display("FAIL dmem_req_cycles op=%b: got %0d expected %0d", op, dmem_cnt, exp_dmem);
    end
    if (we_cnt !== ((op == OP_STORE) ? m + 1 : 0)) begin
      errors++; $display("FAIL dmem_we_cycles op=%b: got %0d expected %0d", op, we_cnt, (op == OP_STORE) ? m + 1 : 0);
    end
    if (rw_cnt !== (writes_reg(op) ? 1 : 0) || m2r_cnt !== ((op == OP_LOAD) ? 1 : 0)) begin
      errors++; $display("FAIL reg_write op=%b: got writes=%0d mem_to_reg=%0d expected %0d/%0d",
                         op, rw_cnt, m2r_cnt, writes_reg(op) ? 1 : 0, (op == OP_LOAD) ? 1 : 0);
    end
    if (pcw_cnt !== 1 + ((op == OP_BEQ && z) ? 1 : 0)) begin
      errors++; $display("FAIL pc_write_cycles op=%b z=%b: got %0d expected %0d", op, z, pcw_cnt, 1 + ((op == OP_BEQ && z) ? 1 : 0));
    end
    if (br_cnt !== ((op == OP_BEQ && z) ? 1 : 0)) begin
      errors++; $display("FAIL branch_taken op=%b z=%b: got %0d expected %0d", op, z, br_cnt, (op == OP_BEQ && z) ? 1 : 0);
    end
    exp_instret   = exp_instret + 32'd1;
    w_exp_instret = w_exp_instret + 32'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = 7'($urandom); zero = 1'($urandom);
      imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      #1;
      checks++;
      if (ctrl_vec() !== 13'd0 || state !== 3'd0 || instret !== 32'd0 || w_instret !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs: got ctrl=%b state=%0d instret=%h expected all zero", ctrl_vec(), state, instret);
      end
    end
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    checks++;
    if (state !== FETCH || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got state=%0d imem_req=%b expected FETCH with imem_req=1", state, imem_req);
    end
    exp_instret   = 32'd0;
    w_exp_instret = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_mid_memory();
    bit seen, retired;
    seen = 0; retired = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      opcode = OP_STORE; imem_ready = 1'b1; dmem_ready = 1'b0;
      #1;
      if (retire) retired = 1;
      if (dmem_req) seen = 1;
    end
    checks++;
    if (!seen || retired) begin
      errors++;
      $display("FAIL store_reach_memory: got seen=%b retired=%b expected 1/0", seen, retired);
    end
    @(negedge clk);
    reset = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 13'd0 || state !== 3'd0 || instret !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_memory: got ctrl=%b state=%0d instret=%h expected all zero", ctrl_vec(), state, instret);
    end
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    exp_instret   = 32'd0;
    w_exp_instret = 32'hFFFF_FFFF;
    checks++;
    if (state !== FETCH || instret !== exp_instret || retire !== 1'b0) begin
      errors++;
      $display("FAIL after_mid_memory_reset: got state=%0d instret=%h retire=%b expected FETCH/0/0", state, instret, retire);
    end
  endtask

  task automatic test_rtype();
    logic [2:0] exp_states [4];
    exp_states = '{FETCH, DECODE, EXECUTE, WRITEBACK};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = OP_R; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
      #1;
      checks++;
      if (state !== exp_states[i]) begin
        errors++; $display("FAIL rtype_state cyc=%0d: got %0d expected %0d", i, state, exp_states[i]);
      end
      checks++;
      if ((reg_write && retire) !== (i == 3)) begin
        errors++; $display("FAIL rtype_writeback cyc=%0d: got rw=%b retire=%b expected %b", i, reg_write, retire, i == 3);
      end
    end
    exp_instret   = exp_instret + 32'd1;
    w_exp_instret = w_exp_instret + 32'd1;
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL rtype_instret: got %h expected %h", instret, exp_instret);
    end
  endtask

  task automatic test_load_wait();
    run_instr(OP_LOAD, 1'b0, 0, 2);
  endtask

  task automatic test_beq();
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [5];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ};
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 4)], 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_trap();
    bit trapped;
    trapped = 0;
    for (int i = 0; i < 10 && !trapped; i++) begin
      @(negedge clk);
      opcode = 7'b1111111; imem_ready = 1'b1; dmem_ready = 1'b0;
      #1;
      if (state == TRAP) trapped = 1;
    end
    checks++;
    if (!trapped) begin
      errors++; $display("FAIL trap_entry: got state=%0d expected TRAP", state);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 7'($urandom); zero = 1'($urandom);
      imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      #1;
      checks++;
      if (ctrl_vec() !== 13'b0_0000_0000_0010 || state !== TRAP) begin
        errors++; $display("FAIL trap_hold cyc=%0d: got ctrl=%b state=%0d expected only illegal", i, ctrl_vec(), state);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 13'd0) begin
      errors++; $display("FAIL trap_reset: got ctrl=%b expected zero", ctrl_vec());
    end
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b0;
    #1;
    exp_instret   = 32'd0;
    w_exp_instret = 32'hFFFF_FFFF;
    checks++;
    if (state !== FETCH || illegal !== 1'b0 || instret !== exp_instret) begin
      errors++; $display("FAIL trap_exit: got state=%0d illegal=%b instret=%h expected FETCH/0/0", state, illegal, instret);
    end
  endtask

  task automatic test_wrap();
    checks++;
    if (w_instret !== w_exp_instret) begin
      errors++; $display("FAIL wrap_preload: got %h expected %h", w_instret, w_exp_instret);
    end
    run_instr(OP_I, 1'b0, 1, 0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    checks++;
    if (w_instret !== w_exp_instret || w_exp_instret !== 32'd0) begin
      errors++; $display("FAIL wrap_rollover: got %h expected %h", w_instret, 32'd0);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL final_instret: got %h expected %h", instret, exp_instret);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    exp_instret = '0; w_exp_instret = 32'hFFFF_FFFF;
    test_reset();
    test_reset_mid_memory();
    test_rtype();
    test_load_wait();
    test_beq();
    test_random();
    test_trap();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
